// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back front end: request payload and
// the source tag carried alongside the registered write port.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] idx);
    return (idx == '0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; head is the oldest entry and is valid
// whenever empty is low. Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push at full is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: merges ALU and buffered memory
// results into the single registered write port and tracks pending load targets.
module regfile_writeback
  import wb_pkg::wb_req_t, wb_pkg::wb_src_e, wb_pkg::WB_NONE, wb_pkg::WB_ALU,
         wb_pkg::WB_MEM, wb_pkg::is_x0;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  chk_busy1,
  output logic                  chk_busy2,
  output logic                  alu_stall,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       wd
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Memory handshake: an entry transfers on a cycle where mem_valid and
  // mem_ready are both high; mem_ready depends only on the registered fill level.
  wb_req_t fifo_in, fifo_head;
  logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic    alu_req;

  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  wb_src_e               src_q, src_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign fifo_in.rd   = mem_rd;
  assign fifo_in.data = mem_data;
  assign mem_ready    = !fifo_full;
  assign fifo_push    = mem_valid && mem_ready;

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A write to x0 from the ALU is no request at all, so the FIFO may drain.
  assign alu_req  = alu_valid && !is_x0(alu_rd);
  assign fifo_pop = !fifo_empty && !alu_req;

  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wd_d       = wd_q;
    src_d      = WB_NONE;
    if (alu_req) begin
      regwrite_d = 1'b1;
      rd_d       = alu_rd;
      wd_d       = alu_data;
      src_d      = WB_ALU;
    end else if (fifo_pop) begin
      regwrite_d = !is_x0(fifo_head.rd);
      rd_d       = fifo_head.rd;
      wd_d       = fifo_head.data;
      src_d      = WB_MEM;
    end
  end

  // Counts cycles the buffer waited behind the ALU; saturates so a stalled
  // ALU that ignores alu_stall keeps the stall asserted until a pop happens.
  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    stall_d = (starve_d == STARVE_MAX);
  end

  always_comb begin
    pending_d = pending_q;
    if (regwrite_q && (src_q == WB_MEM)) pending_d[rd_q] = 1'b0;
    if (issue_valid && !is_x0(issue_rd)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      src_q      <= WB_NONE;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      pending_q  <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
      src_q      <= src_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      pending_q  <= pending_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign rd        = rd_q;
  assign wd        = wd_q;
  assign alu_stall = stall_q;
  assign chk_busy1 = pending_q[chk_rs1];
  assign chk_busy2 = pending_q[chk_rs2];

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: each scenario task drives vectors and
// compares outputs against hand-computed values.
module tb_regfile_writeback;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int W    = RAW + XLEN;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [RAW-1:0]  alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [RAW-1:0]  mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [RAW-1:0]  issue_rd;
  logic [RAW-1:0]  chk_rs1, chk_rs2;
  logic            chk_busy1, chk_busy2;
  logic            alu_stall;
  logic            RegWrite;
  logic [RAW-1:0]  rd;
  logic [XLEN-1:0] wd;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_writeback #(
    .XLEN           (XLEN),
    .REG_ADDR_W     (RAW),
    .MEM_FIFO_DEPTH (4),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .alu_stall   (alu_stall),
    .RegWrite    (RegWrite),
    .rd          (rd),
    .wd          (wd)
  );

  // ALU must stay quiet while alu_stall is high.
  always @(negedge clk) begin
    if (!reset && alu_stall) begin
      n_tests++;
      if (alu_valid) begin
        n_fail++;
        $display("FAIL protocol_stall: alu_valid=1 while alu_stall=1 at %0t", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    mem_valid   = 1'b0;
    mem_rd      = '0;
    mem_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    chk_rs1 = 5'd5;
    chk_rs2 = 5'd0;
    reset = 1'b1;
    step();
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %0b want 0", RegWrite); end
    n_tests++; if (rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd); end
    n_tests++; if (wd !== 32'h0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", wd); end
    n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready: got %0b want 1", mem_ready); end
    n_tests++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %0b want 0", chk_busy1); end
    n_tests++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", alu_stall); end
    reset = 1'b0;
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_after_regwrite: got %0b want 0", RegWrite); end
  endtask

  task automatic test_alu();
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    step();
    n_tests++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %0b want 1", RegWrite); end
    n_tests++; if (rd !== 5'd3) begin n_fail++; $display("FAIL alu_rd: got %0d want 3", rd); end
    n_tests++; if (wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wd: got %h want deadbeef", wd); end
    alu_rd = 5'd0; alu_data = 32'h00000055;
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu_x0_regwrite: got %0b want 0", RegWrite); end
    n_tests++; if (rd !== 5'd3) begin n_fail++; $display("FAIL alu_x0_rd_hold: got %0d want 3", rd); end
    n_tests++; if (wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_x0_wd_hold: got %h want deadbeef", wd); end
    drive_idle();
    step();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    chk_rs1 = 5'd7;
    chk_rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    n_tests++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set: got %0b want 1", chk_busy1); end
    n_tests++; if (chk_busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_x0: got %0b want 0", chk_busy2); end
    n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL sb_mem_ready: got %0b want 1", mem_ready); end
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
    step();
    mem_valid = 1'b0;
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL sb_no_bypass: got %0b want 0", RegWrite); end
    n_tests++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_accepted: got %0b want 1", chk_busy1); end
    step();
    n_tests++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL sb_mem_regwrite: got %0b want 1", RegWrite); end
    n_tests++; if (rd !== 5'd7) begin n_fail++; $display("FAIL sb_mem_rd: got %0d want 7", rd); end
    n_tests++; if (wd !== 32'h1234) begin n_fail++; $display("FAIL sb_mem_wd: got %h want 1234", wd); end
    n_tests++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_during_write: got %0b want 1", chk_busy1); end
    step();
    n_tests++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_cleared: got %0b want 0", chk_busy1); end
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL sb_idle_regwrite: got %0b want 0", RegWrite); end

    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h55;
    step();
    mem_valid = 1'b0;
    step();
    n_tests++; if (wd !== 32'h55 || RegWrite !== 1'b1) begin n_fail++; $display("FAIL sb_second_write: got we=%0b wd=%h want we=1 wd=55", RegWrite, wd); end
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    n_tests++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %0b want 1", chk_busy1); end
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h66;
    step();
    mem_valid = 1'b0;
    step();
    step();
    n_tests++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_final_clear: got %0b want 0", chk_busy1); end
  endtask

  task automatic test_x0();
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    step();
    mem_valid = 1'b0;
    n_tests++; if (RegWrite !== 1'b1 || rd !== 5'd2 || wd !== 32'h22) begin n_fail++; $display("FAIL x0_alu_first: got we=%0b rd=%0d wd=%h want 1/2/22", RegWrite, rd, wd); end
    alu_rd = 5'd0; alu_data = 32'h33;
    step();
    alu_valid = 1'b0;
    n_tests++; if (RegWrite !== 1'b1 || rd !== 5'd9 || wd !== 32'h99) begin n_fail++; $display("FAIL x0_alu_lets_pop: got we=%0b rd=%0d wd=%h want 1/9/99", RegWrite, rd, wd); end
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hABC;
    step();
    mem_valid = 1'b0;
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL x0_mem_accept: got %0b want 0", RegWrite); end
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL x0_mem_pop: got %0b want 0", RegWrite); end
    n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL x0_mem_ready: got %0b want 1", mem_ready); end
  endtask

  task automatic test_contention();
    logic            alu_on;
    logic [RAW-1:0]  a_rd;
    logic [XLEN-1:0] a_data;
    logic [W-1:0]    exp;
    int              budget;
    drive_idle();
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      n_tests++;
      if (alu_stall !== ((c == 9) || (c == 18))) begin
        n_fail++; $display("FAIL cont_stall_c%0d: got %0b want %0b", c, alu_stall, (c == 9) || (c == 18));
      end
      n_tests++;
      if (mem_ready !== !((c >= 4) && (c <= 9))) begin
        n_fail++; $display("FAIL cont_ready_c%0d: got %0b want %0b", c, mem_ready, !((c >= 4) && (c <= 9)));
      end
      alu_on    = !alu_stall;
      a_rd      = RAW'((c % 30) + 1);
      a_data    = 32'hC000_0000 + XLEN'(c);
      alu_valid = alu_on;
      alu_rd    = a_rd;
      alu_data  = a_data;
      if (c < 4) begin
        mem_valid = 1'b1;
        mem_rd    = RAW'(10 + c);
        mem_data  = 32'hA0 + XLEN'(c);
        exp_q.push_back({mem_rd, mem_data});
      end else begin
        mem_valid = 1'b0;
      end
      step();
      if (alu_on) begin
        n_tests++;
        if (RegWrite !== 1'b1 || rd !== a_rd || wd !== a_data) begin
          n_fail++; $display("FAIL cont_alu_c%0d: got we=%0b rd=%0d wd=%h want 1/%0d/%h", c, RegWrite, rd, wd, a_rd, a_data);
        end
      end else begin
        exp = exp_q.pop_front();
        n_tests++;
        if (RegWrite !== 1'b1 || {rd, wd} !== exp) begin
          n_fail++; $display("FAIL cont_drain_c%0d: got we=%0b rd/wd=%h want 1/%h", c, RegWrite, {rd, wd}, exp);
        end
      end
    end
    drive_idle();
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      step();
      budget++;
      exp = exp_q.pop_front();
      n_tests++;
      if (RegWrite !== 1'b1 || {rd, wd} !== exp) begin
        n_fail++; $display("FAIL cont_order: got we=%0b rd/wd=%h want 1/%h", RegWrite, {rd, wd}, exp);
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cont_timeout: %0d entries left want 0", exp_q.size()); end
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL cont_no_extra: got %0b want 0", RegWrite); end
    n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL cont_empty_ready: got %0b want 1", mem_ready); end
  endtask

  task automatic test_fifo_wrap();
    logic            alu_on;
    logic            accept;
    logic [XLEN-1:0] a_data;
    logic [W-1:0]    exp;
    logic [W-1:0]    pushed;
    int              push_idx;
    int              writes;
    drive_idle();
    exp_q.delete();
    push_idx = 0;
    writes   = 0;
    for (int c = 0; c < 60; c++) begin
      if (push_idx == 10 && exp_q.size() == 0) break;
      alu_on    = (c < 5);
      a_data    = 32'hB000_0000 + XLEN'(c);
      alu_valid = alu_on;
      alu_rd    = 5'd1;
      alu_data  = a_data;
      mem_valid = (push_idx < 10);
      mem_rd    = RAW'(16 + push_idx);
      mem_data  = 32'hF00 + XLEN'(push_idx);
      pushed    = {mem_rd, mem_data};
      accept    = mem_valid && mem_ready;
      if (c == 4 || c == 5) begin
        n_tests++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_full_c%0d: got %0b want 0", c, mem_ready); end
      end
      n_tests++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL wrap_stall_c%0d: got %0b want 0", c, alu_stall); end
      step();
      if (alu_on) begin
        n_tests++;
        if (RegWrite !== 1'b1 || rd !== 5'd1 || wd !== a_data) begin
          n_fail++; $display("FAIL wrap_alu_c%0d: got we=%0b rd=%0d wd=%h want 1/1/%h", c, RegWrite, rd, wd, a_data);
        end
      end else if (RegWrite === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL wrap_unexpected: got rd/wd=%h want no write", {rd, wd});
        end else begin
          exp = exp_q.pop_front();
          writes++;
          if ({rd, wd} !== exp) begin
            n_fail++; $display("FAIL wrap_order: got %h want %h", {rd, wd}, exp);
          end
        end
      end
      if (accept) begin
        exp_q.push_back(pushed);
        push_idx++;
      end
    end
    drive_idle();
    n_tests++; if (writes != 10) begin n_fail++; $display("FAIL wrap_count: got %0d want 10", writes); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_left: got %0d want 0", exp_q.size()); end
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL wrap_no_dup: got %0b want 0", RegWrite); end
  endtask

  task automatic test_mid_reset();
    drive_idle();
    chk_rs1 = 5'd3;
    chk_rs2 = 5'd4;
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    n_tests++; if (chk_busy1 !== 1'b1 || chk_busy2 !== 1'b1) begin n_fail++; $display("FAIL mr_pending: got %0b%0b want 11", chk_busy1, chk_busy2); end
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1;
      mem_rd    = RAW'(3 + i);
      mem_data  = 32'hD0 + XLEN'(i);
      step();
    end
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mr_regwrite: got %0b want 0", RegWrite); end
    n_tests++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %0b want 1", mem_ready); end
    n_tests++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %0b%0b want 00", chk_busy1, chk_busy2); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mr_stale_write_%0d: got rd=%0d wd=%h want none", i, rd, wd); end
    end
    for (int r = 0; r < 32; r++) begin
      chk_rs1 = RAW'(r);
      #1;
      n_tests++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL mr_busy_r%0d: got 1 want 0", r); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    chk_rs1 = '0;
    chk_rs2 = '0;
    test_reset();
    test_alu();
    test_scoreboard();
    test_x0();
    test_contention();
    test_fifo_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
